hkspi_slave: RTL

- Clock-domain SPI slave that sits directly downstream of the UART-to-SPI bridge.
- Consumes its spi_csb/spi_sck/spi_sdi and drives spi_sdo back to it.
- Decodes the housekeeping SPI protocol (command byte, address byte, streamed data bytes) into a simple single-cycle register bus.
- SPI inputs are oversampled in the clk domain; no logic is clocked by SCK.

---
 rtl/hkspi_slave.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/hkspi_slave.sv
// Housekeeping SPI slave: oversamples csb/sck/sdi in the clk domain and decodes command/address/data bytes
// into a single-cycle register bus. Define HKSPI_FIXED_LEN_EN to honour the command byte-count field [5:3].
module hkspi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_csb,
  input  logic       spi_sck,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       hk_active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMMAND = 3'd1,
    ADDRESS = 3'd2,
    DATA    = 3'd3,
    IGNORE  = 3'd4
  } state_t;

  localparam logic [7:0] ADDR_STEP = (AUTO_INC != 0) ? 8'd1 : 8'd0;

  logic [SYNC_STAGES-1:0] csb_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   csb_prev_q;
  logic                   sck_prev_q;

  logic csb_s;
  logic sck_s;
  logic sdi_s;
  logic sck_rise_s;
  logic sck_fall_s;
  logic csb_fall_s;
  logic byte_done_s;
  logic last_byte_s;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] bit_cnt_d;
  logic [7:0] rx_q;
  logic [7:0] rx_d;
  logic [7:0] tx_q;
  logic       wr_flag_q;
  logic       rd_flag_q;
  logic       inc_pend_q;
  logic       re_after_inc_q;
  logic       ld_pend_q;

  logic       sdo_q;
  logic       sdo_oe_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       re_q;
  logic       active_q;

`ifdef HKSPI_FIXED_LEN_EN
  logic [2:0] len_q;
  logic [2:0] data_cnt_q;
`endif

  // Input synchronizers plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_sync_q <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      csb_prev_q <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      csb_prev_q <= csb_s;
      sck_prev_q <= sck_s;
    end
  end

  assign csb_s      = csb_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign csb_fall_s = ~csb_s & csb_prev_q;

  assign rx_d      = {rx_q[6:0], sdi_s};
  assign bit_cnt_d = bit_cnt_q + 3'd1;

  // A deasserted csb in the same cycle suppresses the byte, so no strobe can follow an abort.
  assign byte_done_s = sck_rise_s & ~csb_s & (bit_cnt_q == 3'd7) &
                       ((state_q == COMMAND) || (state_q == ADDRESS) || (state_q == DATA));

`ifdef HKSPI_FIXED_LEN_EN
  assign last_byte_s = (len_q != 3'd0) && ((data_cnt_q + 3'd1) == len_q);
`else
  assign last_byte_s = 1'b0;
`endif

  // Protocol FSM, register-bus pipeline and SDO shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      rx_q           <= 8'd0;
      tx_q           <= 8'd0;
      wr_flag_q      <= 1'b0;
      rd_flag_q      <= 1'b0;
      inc_pend_q     <= 1'b0;
      re_after_inc_q <= 1'b0;
      ld_pend_q      <= 1'b0;
      sdo_q          <= 1'b0;
      sdo_oe_q       <= 1'b0;
      addr_q         <= 8'd0;
      wdata_q        <= 8'd0;
      we_q           <= 1'b0;
      re_q           <= 1'b0;
      active_q       <= 1'b0;
`ifdef HKSPI_FIXED_LEN_EN
      len_q          <= 3'd0;
      data_cnt_q     <= 3'd0;
`endif
    end else begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      ld_pend_q <= re_q;

      // Post-byte pipeline: step the address one cycle after the write strobe, then prefetch.
      if (inc_pend_q) begin
        addr_q     <= addr_q + ADDR_STEP;
        re_q       <= re_after_inc_q;
        inc_pend_q <= 1'b0;
      end

      if (ld_pend_q) begin
        tx_q <= reg_rdata;
      end else if (sck_fall_s && !csb_s && (state_q != IDLE)) begin
        sdo_q <= tx_q[7];
        tx_q  <= {tx_q[6:0], 1'b0};
      end

      if (csb_s) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
        sdo_oe_q <= 1'b0;
      end else begin
        if (sck_rise_s && (state_q != IDLE)) begin
          rx_q      <= rx_d;
          bit_cnt_q <= bit_cnt_d;
        end

        case (state_q)
          IDLE: begin
            if (csb_fall_s) begin
              state_q   <= COMMAND;
              active_q  <= 1'b1;
              bit_cnt_q <= 3'd0;
              rx_q      <= 8'd0;
            end
          end
          COMMAND: begin
            if (byte_done_s) begin
              wr_flag_q <= rx_d[7];
              rd_flag_q <= rx_d[6];
`ifdef HKSPI_FIXED_LEN_EN
              len_q      <= rx_d[5:3];
              data_cnt_q <= 3'd0;
`endif
              state_q   <= (rx_d[7:6] != 2'b00) ? ADDRESS : IGNORE;
            end
          end
          ADDRESS: begin
            if (byte_done_s) begin
              addr_q   <= rx_d;
              re_q     <= rd_flag_q;
              sdo_oe_q <= rd_flag_q;
              state_q  <= DATA;
            end
          end
          DATA: begin
            if (byte_done_s) begin
              if (wr_flag_q) begin
                wdata_q <= rx_d;
                we_q    <= 1'b1;
              end
              inc_pend_q     <= 1'b1;
              re_after_inc_q <= rd_flag_q & ~last_byte_s;
`ifdef HKSPI_FIXED_LEN_EN
              data_cnt_q     <= data_cnt_q + 3'd1;
`endif
              if (last_byte_s) begin
                state_q  <= IGNORE;
                sdo_oe_q <= 1'b0;
              end
            end
          end
          IGNORE: begin
            state_q <= IGNORE;
          end
          default: begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            sdo_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_sdo    = sdo_q;
  assign spi_sdo_oe = sdo_oe_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_we     = we_q;
  assign reg_re     = re_q;
  assign hk_active  = active_q;

endmodule
